// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and default line constants
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DEF_CLK_FREQ = 100_000_000;
  localparam int DEF_BAUD     = 9600;

endpackage

// File: rtl/bit_synchronizer.sv
// rtl/bit_synchronizer.sv - two-flop synchroniser for an asynchronous single-bit input
module bit_synchronizer #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_byte_receiver.sv
// rtl/uart_byte_receiver.sv - 8N1 receiver: mid-bit sampling, start glitch reject, stop check
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_receive,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             rx_s;
  logic             rx_prev_q;
  uart_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_receive_q;
  logic             data_valid_q;
  logic             frame_error_q;

  bit_synchronizer #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev_q      <= 1'b1;
      state_q        <= IDLE;
      cnt_q          <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      data_receive_q <= '0;
      data_valid_q   <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      rx_prev_q     <= rx_s;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Edge-triggered so a line stuck low cannot restart reception.
          if (rx_prev_q && !rx_s) begin
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == HALF_END) begin
            if (!rx_s) begin
              cnt_q     <= '0;
              bit_idx_q <= '0;
              state_q   <= DATA;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_q == BIT_END) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            if (bit_idx_q == 3'd7) state_q <= STOP;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
          if (cnt_q == BIT_END) begin
            state_q <= IDLE;
            if (rx_s) begin
              data_receive_q <= shift_q;
              data_valid_q   <= 1'b1;
            end else begin
              frame_error_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_receive = data_receive_q;
  assign data_valid   = data_valid_q;
  assign frame_error  = frame_error_q;
  assign busy         = (state_q != IDLE);

endmodule
